// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
// slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic              r0_err;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic              r1_err;
  logic [DATA_W-1:0] r1_rdata;

  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Write_Data;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] Read_Data;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_err, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_err, r1_rdata,
    output Mem_Addr, Write_Data, MemWrite, MemRead,
    input  Read_Data
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_err, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_err, r1_rdata,
    input  Mem_Addr, Write_Data, MemWrite, MemRead,
    output Read_Data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter and access sequencer for the 256-byte data memory
// Every access runs IDLE -> ACCESS -> RESP; illegal addresses complete with err and no strobe.
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_BYTES  = 256,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

  state_t            state;
  logic              owner;
  logic              we_q;
  logic              err_q;
  logic              last;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic              mem_write, mem_read;

  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic [DATA_W-1:0] resp_data;

  // win = 1 selects requester 1; on a tie the side not granted last goes next
  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO)
      win = !bus.r0_req;
    else if (bus.r0_req && bus.r1_req)
      win = !last;
    else
      win = !bus.r0_req;
    sel_we    = win ? bus.r1_we    : bus.r0_we;
    sel_addr  = win ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = win ? bus.r1_wdata : bus.r0_wdata;
    sel_err   = (sel_addr[2:0] != 3'b000) || (sel_addr > LAST_OK);
    resp_data = (we_q || err_q) ? '0 : bus.Read_Data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      last       <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_addr   <= '0;
      write_data <= '0;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          rdata0  <= '0;
          rdata1  <= '0;
          if (bus.r0_req || bus.r1_req) begin
            owner      <= win;
            last       <= win;
            we_q       <= sel_we;
            err_q      <= sel_err;
            gnt0       <= !win;
            gnt1       <= win;
            mem_addr   <= sel_addr;
            write_data <= sel_wdata;
            mem_read   <= !sel_we && !sel_err;
            mem_write  <= sel_we && !sel_err;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          rvalid0   <= !owner;
          rvalid1   <= owner;
          err0      <= !owner && err_q;
          err1      <= owner && err_q;
          rdata0    <= owner ? '0 : resp_data;
          rdata1    <= owner ? resp_data : '0;
          state     <= RESP;
        end
        RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          err0    <= 1'b0;
          err1    <= 1'b0;
          rdata0  <= '0;
          rdata1  <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r0_gnt     = gnt0;
  assign bus.r1_gnt     = gnt1;
  assign bus.r0_rvalid  = rvalid0;
  assign bus.r1_rvalid  = rvalid1;
  assign bus.r0_err     = err0;
  assign bus.r1_err     = err1;
  assign bus.r0_rdata   = rdata0;
  assign bus.r1_rdata   = rdata1;
  assign bus.Mem_Addr   = mem_addr;
  assign bus.Write_Data = write_data;
  assign bus.MemWrite   = mem_write;
  assign bus.MemRead    = mem_read;
endmodule
